// File: rtl/ring_mod_mixer_if.sv
// Bus bundle between the tone-generator side and ring_mod_mixer: per-channel
// operands and modes in, one mixed mono sample plus status out.
interface ring_mod_mixer_if #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 2
);
    logic                          lrclk;
    logic [CHANNELS*BITSIZE-1:0]   in1;
    logic [CHANNELS*BITSIZE-1:0]   in2;
    logic [2*CHANNELS-1:0]         mode;
    logic signed [BITSIZE-1:0]     out;
    logic                          out_valid;
    logic                          busy;
    logic                          overrun;

    modport master (
        output lrclk, in1, in2, mode,
        input  out, out_valid, busy, overrun
    );

    modport slave (
        input  lrclk, in1, in2, mode,
        output out, out_valid, busy, overrun
    );
endinterface

// File: rtl/ring_mod_mixer.sv
// N-channel ring modulator / mixer: serial shift-add Q1.(BITSIZE-1) multiply per channel on bclk,
// saturating sum into one mono sample per frame. Define RINGMOD_ROUND_EN for round-half-up scaling.
module ring_mod_mixer #(
    parameter int BITSIZE  = 16,
    parameter int CHANNELS = 2
) (
    input  logic              bclk,
    input  logic              resetn,
    ring_mod_mixer_if.slave   bus
);
    localparam int W  = BITSIZE;
    localparam int PW = 2 * BITSIZE;
    localparam int AW = BITSIZE + $clog2(CHANNELS) + 1;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = $clog2(BITSIZE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic signed [PW-1:0] P_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [AW-1:0] A_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] A_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  W_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  W_MIN = {1'b1, {(W-1){1'b0}}};
`ifdef RINGMOD_ROUND_EN
    localparam logic signed [PW-1:0] P_HALF = {{(PW-W+1){1'b0}}, 1'b1, {(W-2){1'b0}}};
`endif

    function automatic logic signed [PW-1:0] sext_p(input logic signed [W-1:0] v);
        return {{(PW-W){v[W-1]}}, v};
    endfunction

    function automatic logic signed [AW-1:0] sext_a(input logic signed [W-1:0] v);
        return {{(AW-W){v[W-1]}}, v};
    endfunction

    // Product back to Q1.(W-1); only -1 * -1 can exceed the positive limit.
    function automatic logic signed [W-1:0] scale_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
`ifdef RINGMOD_ROUND_EN
        s = (p + P_HALF) >>> (W - 1);
`else
        s = p >>> (W - 1);
`endif
        if (s > P_MAX)      return W_MAX;
        else if (s < P_MIN) return W_MIN;
        else                return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] acc_sat(input logic signed [AW-1:0] a);
        if (a > A_MAX)      return W_MAX;
        else if (a < A_MIN) return W_MIN;
        else                return a[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] select_term(
        input logic [1:0]            m,
        input logic signed [PW-1:0]  p,
        input logic signed [W-1:0]   a,
        input logic signed [W-1:0]   b
    );
        case (m)
            2'b00:   return scale_sat(p);
            2'b01:   return a;
            2'b10:   return b;
            default: return '0;
        endcase
    endfunction

    logic [1:0]                  state_q, state_d;
    logic                        lrclk_q, lrclk_d;
    logic [CW-1:0]               ch_q, ch_d;
    logic [BW-1:0]               bit_q, bit_d;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic signed [W-1:0]         out_q, out_d;
    logic                        out_valid_q, out_valid_d;
    logic                        busy_q, busy_d;
    logic                        overrun_q, overrun_d;

    logic [CHANNELS*W-1:0]       in1_q, in1_d;
    logic [CHANNELS*W-1:0]       in2_q, in2_d;
    logic [2*CHANNELS-1:0]       mode_q, mode_d;
    logic signed [PW-1:0]        prod_q, prod_d;
    logic signed [PW-1:0]        mcand_q, mcand_d;
    logic [W-1:0]                mplier_q, mplier_d;

    logic                        frame_edge;
    logic                        last_ch;
    logic [CHANNELS*W-1:0]       in1_nxt, in2_nxt;
    logic [2*CHANNELS-1:0]       mode_nxt;
    logic signed [W-1:0]         term;

    assign frame_edge = bus.lrclk & ~lrclk_q;
    assign last_ch    = (ch_q == CW'(CHANNELS - 1));

    // Latched operands are consumed as a shift queue: slot 0 is always the current channel.
    assign in1_nxt  = in1_q >> W;
    assign in2_nxt  = in2_q >> W;
    assign mode_nxt = mode_q >> 2;
    assign term     = select_term(mode_q[1:0], prod_q, in1_q[W-1:0], in2_q[W-1:0]);

    always_comb begin
        state_d     = state_q;
        lrclk_d     = bus.lrclk;
        ch_d        = ch_q;
        bit_d       = bit_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q | (frame_edge & busy_q);
        in1_d       = in1_q;
        in2_d       = in2_q;
        mode_d      = mode_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;

        if (out_valid_q) busy_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (frame_edge && !busy_q) begin
                    in1_d    = bus.in1;
                    in2_d    = bus.in2;
                    mode_d   = bus.mode;
                    mcand_d  = sext_p(bus.in1[W-1:0]);
                    mplier_d = bus.in2[W-1:0];
                    prod_d   = '0;
                    ch_d     = '0;
                    bit_d    = '0;
                    acc_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                // The multiplier's sign bit carries weight -2^(W-1), so the last step subtracts.
                if (mplier_q[0]) begin
                    if (bit_q == BW'(W - 1)) prod_d = prod_q - mcand_q;
                    else                     prod_d = prod_q + mcand_q;
                end
                mcand_d  = mcand_q <<< 1;
                mplier_d = mplier_q >> 1;
                bit_d    = bit_q + BW'(1);
                if (bit_q == BW'(W - 1)) state_d = S_ACC;
            end
            S_ACC: begin
                acc_d = acc_q + sext_a(term);
                if (last_ch) begin
                    state_d = S_OUT;
                end else begin
                    ch_d     = ch_q + CW'(1);
                    in1_d    = in1_nxt;
                    in2_d    = in2_nxt;
                    mode_d   = mode_nxt;
                    mcand_d  = sext_p(in1_nxt[W-1:0]);
                    mplier_d = in2_nxt[W-1:0];
                    prod_d   = '0;
                    bit_d    = '0;
                    state_d  = S_MUL;
                end
            end
            S_OUT: begin
                out_d       = acc_sat(acc_q);
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge bclk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            lrclk_q     <= 1'b0;
            ch_q        <= '0;
            bit_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lrclk_q     <= lrclk_d;
            ch_q        <= ch_d;
            bit_q       <= bit_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    // Datapath registers are only consumed after a frame latch, so they need no reset.
    always_ff @(posedge bclk) begin
        in1_q    <= in1_d;
        in2_q    <= in2_d;
        mode_q   <= mode_d;
        prod_q   <= prod_d;
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_ring_mod_mixer.sv
// Directed bench for ring_mod_mixer: one single-channel and one dual-channel instance.
module tb_ring_mod_mixer;
    logic bclk;
    logic rn1, rn2;
    int   n_tests, n_fail;

    ring_mod_mixer_if #(.BITSIZE(16), .CHANNELS(1)) if1 ();
    ring_mod_mixer_if #(.BITSIZE(16), .CHANNELS(2)) if2 ();

    ring_mod_mixer #(.BITSIZE(16), .CHANNELS(1)) dut1 (.bclk(bclk), .resetn(rn1), .bus(if1));
    ring_mod_mixer #(.BITSIZE(16), .CHANNELS(2)) dut2 (.bclk(bclk), .resetn(rn2), .bus(if2));

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic lr, input logic rn);
        if (sel == 1) begin if1.lrclk = lr; rn1 = rn; end
        else          begin if2.lrclk = lr; rn2 = rn; end
    endtask

    // One frame: edge sampled at rise 0; optional extra edge at rise edge_at,
    // reset held low for rises rst_at and rst_at+1, inputs scrambled after the latch.
    task automatic run_frame(input int sel, input int edge_at, input int rst_at, input bit scr,
                             input int budget,
                             output int vcyc, output int nval, output logic [15:0] oval,
                             output logic busy_end, output logic ovr_end,
                             output logic [15:0] out_end, output logic busy_rst);
        logic lr, rn, v, b;
        vcyc = -1; nval = 0; oval = '0; busy_rst = 1'b1;
        @(negedge bclk);
        for (int k = 0; k <= budget; k++) begin
            lr = (k == 0) || (k == edge_at);
            rn = !(rst_at >= 0 && k >= rst_at && k < rst_at + 2);
            drive(sel, lr, rn);
            if (scr && k == 3) begin
                if (sel == 1) begin if1.in1 = 16'h1234; if1.in2 = 16'h5678; if1.mode = 2'b01; end
                else begin if2.in1 = 32'h12345678; if2.in2 = 32'h0; if2.mode = 4'b0101; end
            end
            @(posedge bclk);
            @(negedge bclk);
            v = (sel == 1) ? if1.out_valid : if2.out_valid;
            b = (sel == 1) ? if1.busy : if2.busy;
            if (k == rst_at) busy_rst = b;
            if (v) begin
                nval++;
                if (vcyc < 0) vcyc = k;
                oval = (sel == 1) ? if1.out : if2.out;
            end
        end
        drive(sel, 1'b0, 1'b1);
        busy_end = (sel == 1) ? if1.busy : if2.busy;
        ovr_end  = (sel == 1) ? if1.overrun : if2.overrun;
        out_end  = (sel == 1) ? if1.out : if2.out;
    endtask

    int          vc, nv;
    logic [15:0] ov, oe;
    logic        be, ove, br;

    initial begin
        n_tests = 0; n_fail = 0;
        rn1 = 1'b0; rn2 = 1'b0;
        if1.lrclk = 1'b0; if1.in1 = '0; if1.in2 = '0; if1.mode = '0;
        if2.lrclk = 1'b0; if2.in1 = '0; if2.in2 = '0; if2.mode = '0;
        repeat (3) @(posedge bclk);
        @(negedge bclk);
        chk("rst_out",       32'(if1.out),       32'h0);
        chk("rst_out_valid", 32'(if1.out_valid), 32'h0);
        chk("rst_busy",      32'(if1.busy),      32'h0);
        chk("rst_overrun",   32'(if1.overrun),   32'h0);
        chk("rst_busy_ch2",  32'(if2.busy),      32'h0);
        rn1 = 1'b1; rn2 = 1'b1;
        repeat (2) @(negedge bclk);

        // 0.5 * 0.5
        if1.in1 = 16'h4000; if1.in2 = 16'h4000; if1.mode = 2'b00;
        run_frame(1, -1, -1, 1'b0, 40, vc, nv, ov, be, ove, oe, br);
        chk("t1_latency", 32'(vc), 32'd18);
        chk("t1_out",     32'(ov), 32'h2000);
        chk("t1_nvalid",  32'(nv), 32'd1);
        chk("t1_busy_end", 32'(be), 32'h0);

        if1.in1 = 16'h8000; if1.in2 = 16'h8000;
        run_frame(1, -1, -1, 1'b0, 40, vc, nv, ov, be, ove, oe, br);
        chk("t2_neg1_sq", 32'(ov), 32'h7FFF);

        if1.in1 = 16'h8000; if1.in2 = 16'h7FFF;
        run_frame(1, -1, -1, 1'b0, 40, vc, nv, ov, be, ove, oe, br);
        chk("t2_neg_max", 32'(ov), 32'h8001);

        if1.in1 = 16'h0001; if1.in2 = 16'h4000;
        run_frame(1, -1, -1, 1'b0, 40, vc, nv, ov, be, ove, oe, br);
`ifdef RINGMOD_ROUND_EN
        chk("t4_round", 32'(ov), 32'h0001);
`else
        chk("t4_round", 32'(ov), 32'h0000);
`endif

        // Dual channel: ch0 product, ch1 pass-through / mute / in2
        if2.in1 = {16'h7000, 16'h7FFF}; if2.in2 = {16'h0000, 16'h7FFF}; if2.mode = {2'b01, 2'b00};
        run_frame(2, -1, -1, 1'b0, 45, vc, nv, ov, be, ove, oe, br);
        chk("t3_latency", 32'(vc), 32'd35);
        chk("t3_sat_pos", 32'(ov), 32'h7FFF);
        chk("t3_nvalid",  32'(nv), 32'd1);

        if2.in1 = {16'h7000, 16'h7FFF}; if2.in2 = {16'h0000, 16'h7FFF}; if2.mode = {2'b11, 2'b00};
        run_frame(2, -1, -1, 1'b0, 45, vc, nv, ov, be, ove, oe, br);
        chk("t3_mute", 32'(ov), 32'h7FFE);

        if2.in1 = {16'h0000, 16'h9000}; if2.in2 = {16'h9000, 16'h0000}; if2.mode = {2'b10, 2'b01};
        run_frame(2, -1, -1, 1'b0, 45, vc, nv, ov, be, ove, oe, br);
        chk("t3_sat_neg", 32'(ov), 32'h8000);

        // Extra edge at cycle 10 plus input changes after the latch
        if1.in1 = 16'h4000; if1.in2 = 16'hC000; if1.mode = 2'b00;
        run_frame(1, 10, -1, 1'b1, 40, vc, nv, ov, be, ove, oe, br);
        chk("t5_overrun", 32'(ove), 32'h1);
        chk("t5_out",     32'(ov),  32'hE000);
        chk("t5_latency", 32'(vc),  32'd18);
        chk("t5_nvalid",  32'(nv),  32'd1);

        // Reset at cycle 12 aborts the frame
        if1.in1 = 16'h4000; if1.in2 = 16'h4000; if1.mode = 2'b00;
        run_frame(1, -1, 12, 1'b0, 40, vc, nv, ov, be, ove, oe, br);
        chk("t6_nvalid",   32'(nv),  32'd0);
        chk("t6_busy_rst", 32'(br),  32'h0);
        chk("t6_out",      32'(oe),  32'h0);
        chk("t6_overrun",  32'(ove), 32'h0);

        if1.in1 = 16'h2000; if1.in2 = 16'h7FFF; if1.mode = 2'b00;
        run_frame(1, -1, -1, 1'b0, 40, vc, nv, ov, be, ove, oe, br);
        chk("t6_after_lat", 32'(vc), 32'd18);
`ifdef RINGMOD_ROUND_EN
        chk("t6_after_out", 32'(ov), 32'h2000);
`else
        chk("t6_after_out", 32'(ov), 32'h1FFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
